kbd_test_selector: RTL and testbench
====================================

# kbd_test_selector

Keyboard-driven video-mode and self-test selector for the board-test image. It consumes decoded PS/2 key events from the existing `ps2_port` receiver and drives the video mode (`mode`, `vga`) and the text-window hide flag. It issues one-at-a-time test requests to up to `NUM_TESTS` test engines over a req/ack handshake, with abort and timeout. It replaces the fixed single-cycle test strobes with a handshaked, parametrised channel set.

## Interface
- `NUM_TESTS`, 5: number of test channels, range 1..6; channel i is selected by digit key 4+i.
- `ACK_TIMEOUT`, 1048576: cycles allowed in REQ before abandoning the request; must be ≥2.
- `clk` in 1: single system clock.
- `rst` in 1: asynchronous, active-high reset.
- `key_event` in 1: 1-cycle strobe, new key event valid.
- `scancode` in 8: make/break code, valid with `key_event`.
- `released` in 1: 1 = break, 0 = make; valid with `key_event`.
- `extended` in 1: 1 = E0-prefixed key; valid with `key_event`.
- `test_ack` in NUM_TESTS: per-channel acknowledge from the test engines.
- `test_req` out NUM_TESTS: one-hot request, held until acked.
- `busy` out 1: state ≠ IDLE.
- `active_test` out 3: index of the current or last requested channel.
- `rejected` out 1: 1-cycle pulse when a test key arrives while busy.
- `timeout` out 1: 1-cycle pulse when a request is abandoned.
- `mode` out 1: video mode select.
- `vga` out 1: VGA/RGB select.
- `hidetextwindow` out 1: high while Space is held.

## Operation
- Only `key_event` cycles with `extended=0` are acted on. Extended events are ignored.
- Space (0x29): `hidetextwindow <= ~released` on both make and break.
- All other actions fire on break (`released=1`) only. Typematic make repeats therefore have no effect.
- Video keys, any state:
  - key 1 (0x16): mode=0, vga=0.
  - key 2 (0x1E): mode=1, vga=0.
  - key 3 (0x26): mode=1, vga=1.
  - F1 (0x05): cycles config 1→2→3→1. A config is defined by {mode,vga}: 00 = 1, 10 = 2, 11 = 3. The unreachable 01 steps to 2.
- Test keys: 4, 5, 6, 7, 8, 9 (0x25, 0x2E, 0x36, 0x3D, 0x3E, 0x46) map to channels 0..5. Keys with index ≥ NUM_TESTS are ignored.
- Test FSM:
  - IDLE: a valid test key sets `active_test`, drives `test_req[i]=1` and enters REQ. The timeout counter clears.
  - REQ: if `test_ack[active_test]=1`, drop req and go to WAIT. If Esc (0x76, break) arrives, drop req and go to IDLE. If the counter reaches ACK_TIMEOUT-1, drop req, pulse `timeout` and go to IDLE.
  - WAIT: when `test_ack[active_test]=0`, go to IDLE.
  - A test key in REQ or WAIT is discarded and pulses `rejected`. Esc in WAIT and IDLE is ignored.
- Acks on channels other than `active_test` are ignored in every state.
- Reset values: mode=1, vga=1, hidetextwindow=0, test_req=0, busy=0, active_test=0, rejected=0, timeout=0. FSM goes to IDLE and the counter to 0.
- `rst` asserted mid-request drops `test_req` immediately (asynchronous), regardless of ack.

## Timing
- All outputs are registered. A key_event in cycle N produces its effect on outputs in N+1.
- Ack seen high in cycle N: `test_req` is low in N+1 and `busy` stays high until the cycle after ack is seen low.
- If `key_event` and ack (or timeout) coincide, the FSM transition is evaluated against the pre-transition state. A test key in that cycle is therefore rejected. Video and Space keys are always applied.
- Timeout: req is high for exactly ACK_TIMEOUT cycles, then drops and `timeout` pulses in the same cycle.
- Minimum request cycle: IDLE→REQ→WAIT→IDLE takes 3 cycles with an immediate 1-cycle ack.

## Configuration
- `KBD_TEST_SEL_KEYPAD_ALIAS_EN` defined: numeric keypad keys alias the digits.
  - KP1–KP3 (0x69, 0x72, 0x7A) act as video keys.
  - KP4–KP9 (0x6B, 0x73, 0x74, 0x6C, 0x75, 0x7D) act as test keys.
- Undefined: keypad scancodes are ignored.

## Test plan
- Reset, then no input → mode=1, vga=1, test_req=0, busy=0.
- Break of key 2 (0x1E), then F1 break twice → {mode,vga}=10, then 11, then 00.
- Break of key 5 (0x2E), ack held high 3 cycles from the 4th cycle after the event → test_req=00010 for cycles N+1..N+4, busy drops 1 cycle after ack falls, active_test=1.
- Break of key 4 with no ack, ACK_TIMEOUT=16 → test_req[0] high for 16 cycles, single `timeout` pulse, returns to IDLE. Break of key 6 during REQ → `rejected` pulse, test_req unchanged.
- Space make then break → hidetextwindow 1 then 0. With NUM_TESTS=2, break of key 7 → no request.
- With the macro defined, KP6 (0x74) break → test_req[2]=1. Without the macro, no effect. `rst` pulse mid-REQ → test_req=0 asynchronously.

Source files
------------

// File: rtl/kbd_test_selector.sv
// Keyboard-driven video-mode / self-test selector with a handshaked one-at-a-time test request channel.
// Define KBD_TEST_SEL_KEYPAD_ALIAS_EN to let the numeric keypad alias the digit keys.
module kbd_test_selector #(
  parameter int NUM_TESTS   = 5,
  parameter int ACK_TIMEOUT = 1048576
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 key_event_i,
  input  logic [7:0]           scancode_i,
  input  logic                 released_i,
  input  logic                 extended_i,
  input  logic [NUM_TESTS-1:0] test_ack_i,
  output logic [NUM_TESTS-1:0] test_req_o,
  output logic                 busy_o,
  output logic [2:0]           active_test_o,
  output logic                 rejected_o,
  output logic                 timeout_o,
  output logic                 mode_o,
  output logic                 vga_o,
  output logic                 hidetextwindow_o
);
  localparam int CNT_W = $clog2(ACK_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_WAIT = 2'd2} state_t;

  // {hit, mode, vga} for the direct video-mode keys
  function automatic logic [2:0] video_decode(input logic [7:0] sc);
    logic [2:0] r;
    case (sc)
      8'h16:   r = 3'b100;
      8'h1E:   r = 3'b110;
      8'h26:   r = 3'b111;
`ifdef KBD_TEST_SEL_KEYPAD_ALIAS_EN
      8'h69:   r = 3'b100;
      8'h72:   r = 3'b110;
      8'h7A:   r = 3'b111;
`endif
      default: r = 3'b000;
    endcase
    return r;
  endfunction

  // {hit, channel} for the test keys
  function automatic logic [3:0] test_decode(input logic [7:0] sc);
    logic [3:0] r;
    case (sc)
      8'h25:   r = 4'b1000;
      8'h2E:   r = 4'b1001;
      8'h36:   r = 4'b1010;
      8'h3D:   r = 4'b1011;
      8'h3E:   r = 4'b1100;
      8'h46:   r = 4'b1101;
`ifdef KBD_TEST_SEL_KEYPAD_ALIAS_EN
      8'h6B:   r = 4'b1000;
      8'h73:   r = 4'b1001;
      8'h74:   r = 4'b1010;
      8'h6C:   r = 4'b1011;
      8'h75:   r = 4'b1100;
      8'h7D:   r = 4'b1101;
`endif
      default: r = 4'b0000;
    endcase
    return r;
  endfunction

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2:0]           active_test_q, active_test_d;
  logic [NUM_TESTS-1:0] test_req_q, test_req_d;
  logic                 busy_q, busy_d;
  logic                 rejected_q, rejected_d;
  logic                 timeout_q, timeout_d;
  logic                 mode_q, mode_d;
  logic                 vga_q, vga_d;
  logic                 hide_q, hide_d;

  logic       evt_s, brk_s, esc_s, test_hit_s, ack_sel_s;
  logic [2:0] vid_s;
  logic [3:0] tkey_s;

  assign evt_s      = key_event_i & ~extended_i;
  assign brk_s      = evt_s & released_i;
  assign esc_s      = brk_s & (scancode_i == 8'h76);
  assign vid_s      = video_decode(scancode_i);
  assign tkey_s     = test_decode(scancode_i);
  assign test_hit_s = brk_s & tkey_s[3] & (int'(tkey_s[2:0]) < NUM_TESTS);

  // Acknowledge of the currently selected channel only
  always_comb begin
    ack_sel_s = 1'b0;
    for (int i = 0; i < NUM_TESTS; i++) begin
      ack_sel_s = ack_sel_s | (test_ack_i[i] & (active_test_q == 3'(i)));
    end
  end

  // Next-state logic: video mode, hide flag and test FSM
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    active_test_d = active_test_q;
    rejected_d    = 1'b0;
    timeout_d     = 1'b0;
    mode_d        = mode_q;
    vga_d         = vga_q;
    hide_d        = hide_q;

    if (evt_s && (scancode_i == 8'h29)) begin
      hide_d = ~released_i;
    end else begin
      hide_d = hide_q;
    end

    if (brk_s && vid_s[2]) begin
      mode_d = vid_s[1];
      vga_d  = vid_s[0];
    end else if (brk_s && (scancode_i == 8'h05)) begin
      // F1 steps config 1 -> 2 -> 3 -> 1; the unused 01 encoding joins at 2
      case ({mode_q, vga_q})
        2'b00:   {mode_d, vga_d} = 2'b10;
        2'b10:   {mode_d, vga_d} = 2'b11;
        2'b11:   {mode_d, vga_d} = 2'b00;
        default: {mode_d, vga_d} = 2'b10;
      endcase
    end else begin
      mode_d = mode_q;
      vga_d  = vga_q;
    end

    case (state_q)
      S_IDLE: begin
        if (test_hit_s) begin
          state_d       = S_REQ;
          active_test_d = tkey_s[2:0];
          cnt_d         = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        rejected_d = test_hit_s;
        if (ack_sel_s) begin
          state_d = S_WAIT;
        end else if (esc_s) begin
          state_d = S_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = S_IDLE;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WAIT: begin
        rejected_d = test_hit_s;
        if (!ack_sel_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
    for (int i = 0; i < NUM_TESTS; i++) begin
      test_req_d[i] = (state_d == S_REQ) && (active_test_d == 3'(i));
    end
  end

  // State and output registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      active_test_q <= 3'd0;
      test_req_q    <= '0;
      busy_q        <= 1'b0;
      rejected_q    <= 1'b0;
      timeout_q     <= 1'b0;
      mode_q        <= 1'b1;
      vga_q         <= 1'b1;
      hide_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      active_test_q <= active_test_d;
      test_req_q    <= test_req_d;
      busy_q        <= busy_d;
      rejected_q    <= rejected_d;
      timeout_q     <= timeout_d;
      mode_q        <= mode_d;
      vga_q         <= vga_d;
      hide_q        <= hide_d;
    end
  end

  assign test_req_o       = test_req_q;
  assign busy_o           = busy_q;
  assign active_test_o    = active_test_q;
  assign rejected_o       = rejected_q;
  assign timeout_o        = timeout_q;
  assign mode_o           = mode_q;
  assign vga_o            = vga_q;
  assign hidetextwindow_o = hide_q;

endmodule

// File: tb/tb_kbd_test_selector.sv
// Scoreboard bench for kbd_test_selector: a spec-level model pushes per-cycle expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_kbd_test_selector;
  localparam int NT = 5;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          key_event = 1'b0;
  logic [7:0]    scancode = 8'h00;
  logic          released = 1'b0;
  logic          extended = 1'b0;
  logic [NT-1:0] test_ack = '0;
  logic [NT-1:0] test_req;
  logic          busy, rejected, timeout, mode, vga, hide;
  logic [2:0]    active_test;

  kbd_test_selector #(.NUM_TESTS(NT), .ACK_TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst), .key_event_i(key_event), .scancode_i(scancode),
    .released_i(released), .extended_i(extended), .test_ack_i(test_ack),
    .test_req_o(test_req), .busy_o(busy), .active_test_o(active_test),
    .rejected_o(rejected), .timeout_o(timeout), .mode_o(mode), .vga_o(vga),
    .hidetextwindow_o(hide)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NT-1:0] req;
    logic          busy;
    logic [2:0]    act;
    logic          rej;
    logic          to;
    logic          mode;
    logic          vga;
    logic          hide;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: video config number 1..3, request phase 0=idle 1=requesting 2=waiting
  int video_map[logic [7:0]];
  int test_map[logic [7:0]];
  int m_cfg, m_phase, m_chan, m_held;
  bit m_hide, m_rej, m_to;

  task automatic init_maps();
    video_map[8'h16] = 1; video_map[8'h1E] = 2; video_map[8'h26] = 3;
    test_map[8'h25] = 0; test_map[8'h2E] = 1; test_map[8'h36] = 2;
    test_map[8'h3D] = 3; test_map[8'h3E] = 4; test_map[8'h46] = 5;
`ifdef KBD_TEST_SEL_KEYPAD_ALIAS_EN
    video_map[8'h69] = 1; video_map[8'h72] = 2; video_map[8'h7A] = 3;
    test_map[8'h6B] = 0; test_map[8'h73] = 1; test_map[8'h74] = 2;
    test_map[8'h6C] = 3; test_map[8'h75] = 4; test_map[8'h7D] = 5;
`endif
  endtask

  task automatic model_reset();
    m_cfg = 3; m_phase = 0; m_chan = 0; m_held = 0;
    m_hide = 0; m_rej = 0; m_to = 0;
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.req = '0;
    if (m_phase == 1) e.req[m_chan] = 1'b1;
    e.busy = (m_phase != 0);
    e.act  = 3'(m_chan);
    e.rej  = m_rej;
    e.to   = m_to;
    e.mode = (m_cfg >= 2);
    e.vga  = (m_cfg == 3);
    e.hide = m_hide;
    return e;
  endfunction

  task automatic model_step(input logic ke, input logic [7:0] sc, input logic rel,
                            input logic ext, input logic [NT-1:0] ack);
    bit valid, brk, tk, ack_act;
    valid   = ke && !ext;
    brk     = valid && rel;
    tk      = brk && test_map.exists(sc) && (test_map[sc] < NT);
    ack_act = ack[m_chan];
    m_rej = 0;
    m_to  = 0;
    if (valid && sc == 8'h29) m_hide = !rel;
    if (brk && video_map.exists(sc)) m_cfg = video_map[sc];
    else if (brk && sc == 8'h05) m_cfg = (m_cfg % 3) + 1;
    if (m_phase == 0) begin
      if (tk) begin
        m_phase = 1; m_chan = test_map[sc]; m_held = 1;
      end
    end else begin
      if (tk) m_rej = 1;
      if (m_phase == 1) begin
        if (ack_act) m_phase = 2;
        else if (brk && sc == 8'h76) m_phase = 0;
        else if (m_held == TO) begin m_phase = 0; m_to = 1; end
        else m_held++;
      end else if (!ack_act) begin
        m_phase = 0;
      end
    end
  endtask

  // Monitor: one expected output vector per cycle, compared away from the active edge
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e, a;
      e = sb.pop_front();
      a = '{req: test_req, busy: busy, act: active_test, rej: rejected, to: timeout,
            mode: mode, vga: vga, hide: hide};
      n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL outputs t=%0t got req=%b busy=%b act=%0d rej=%b to=%b mode=%b vga=%b hide=%b want req=%b busy=%b act=%0d rej=%b to=%b mode=%b vga=%b hide=%b",
                 $time, a.req, a.busy, a.act, a.rej, a.to, a.mode, a.vga, a.hide,
                 e.req, e.busy, e.act, e.rej, e.to, e.mode, e.vga, e.hide);
      end
    end
  end

  task automatic drive(input logic ke, input logic [7:0] sc, input logic rel,
                       input logic ext, input logic [NT-1:0] ack);
    key_event = ke; scancode = sc; released = rel; extended = ext; test_ack = ack;
    model_step(ke, sc, rel, ext, ack);
    sb.push_back(model_out());
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b0, 1'b0, '0);
  endtask

  task automatic brk_key(input logic [7:0] sc);
    drive(1'b1, sc, 1'b1, 1'b0, '0);
  endtask

  task automatic release_reset();
    key_event = 1'b0; test_ack = '0;
    rst = 1'b0;
    model_reset();
    sb.push_back(model_out());
  endtask

  logic [7:0] codes [22] = '{8'h16, 8'h1E, 8'h26, 8'h05, 8'h25, 8'h2E, 8'h36, 8'h3D,
                             8'h3E, 8'h46, 8'h76, 8'h29, 8'h69, 8'h72, 8'h7A, 8'h6B,
                             8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D, 8'h00};

  initial begin
    init_maps();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    release_reset();
    idle(2);

    // Video keys and F1 cycling
    brk_key(8'h1E); brk_key(8'h05); brk_key(8'h05); brk_key(8'h05); idle(1);

    // Key 5 with ack high for 3 cycles starting 4 cycles after the event
    brk_key(8'h2E);
    idle(3);
    for (int i = 0; i < 3; i++) drive(1'b0, 8'h00, 1'b0, 1'b0, 5'b00010);
    idle(3);

    // Key 4 never acked: timeout, with a rejected key 6 while requesting
    brk_key(8'h25); idle(3); brk_key(8'h36); idle(TO + 2);

    // Space hold, key beyond channel count, keypad alias, Esc abort, extended ignore
    drive(1'b1, 8'h29, 1'b0, 1'b0, '0); idle(1); brk_key(8'h29);
    brk_key(8'h46); idle(1);
    brk_key(8'h74); idle(2); brk_key(8'h76); idle(1);
    drive(1'b1, 8'h3D, 1'b1, 1'b1, '0); idle(1);
    drive(1'b1, 8'h3D, 1'b0, 1'b0, '0); idle(1);

    // Asynchronous reset while a request is outstanding
    brk_key(8'h3E); idle(2);
    n_cmp++;
    if (test_req !== 5'b10000) begin
      n_bad++;
      $display("FAIL pre_reset_req got %b want %b", test_req, 5'b10000);
    end
    #1 rst = 1'b1;
    #1;
    n_cmp++;
    if (test_req !== '0 || busy !== 1'b0 || mode !== 1'b1 || vga !== 1'b1) begin
      n_bad++;
      $display("FAIL async_reset got req=%b busy=%b mode=%b vga=%b want req=0 busy=0 mode=1 vga=1",
               test_req, busy, mode, vga);
    end
    sb.delete();
    @(posedge clk); #1;
    release_reset();
    idle(2);

    // Randomized traffic with varying ack responsiveness
    for (int blk = 0; blk < 60; blk++) begin
      int p;
      p = (blk % 4 == 0) ? 0 : (blk % 4 == 1) ? 1 : (blk % 4 == 2) ? 2 : 8;
      for (int c = 0; c < 40; c++) begin
        logic          ke, rel, ext;
        logic [7:0]    sc;
        logic [NT-1:0] ack;
        ke  = ($urandom_range(0, 3) == 0);
        sc  = codes[$urandom_range(0, 21)];
        if (sc == 8'h00) sc = 8'($urandom_range(0, 255));
        rel = ($urandom_range(0, 9) < 7);
        ext = ($urandom_range(0, 9) == 0);
        for (int b = 0; b < NT; b++) ack[b] = (p != 0) && ($urandom_range(0, p - 1) == 0);
        drive(ke, sc, rel, ext, ack);
      end
    end
    idle(2);

    @(negedge clk); #1;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain got %0d left want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
